// File: rtl/rdata_framer.sv
// rdata_framer: absorbs non-backpressurable DDR read beats in a small FWFT
// buffer and re-emits them as AXI-Stream, with tlast every pkt_len beats and
// sticky overflow / saturating drop counter for lost beats.
// Optional feature macro: RDATA_SEQ_TAG_EN adds m_axis_tuser[15:0], a per-beat
// sequence number that advances on every rdDataEn so dropped beats show as gaps.
//
// Handshake: a beat transfers on any rising clk edge where m_axis_tvalid and
// m_axis_tready are both 1. m_axis_tvalid never depends on m_axis_tready, and
// tdata/tlast hold steady while tvalid is high and tready is low. rdDataEn has
// no ready: a beat arriving while full (and not popping) is dropped.
module rdata_framer #(
  parameter int DATA_WIDTH = 512,
  parameter int DEPTH      = 16,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic [LEN_WIDTH-1:0]       pkt_len,
  input  logic [DATA_WIDTH-1:0]      rdData,
  input  logic                       rdDataEn,
  output logic [DATA_WIDTH-1:0]      m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]    m_axis_tkeep,
  output logic                       m_axis_tlast,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [$clog2(DEPTH):0]     fill_level,
  output logic                       overflow,
  output logic [CNT_WIDTH-1:0]       drop_cnt
`ifdef RDATA_SEQ_TAG_EN
  ,
  output logic [15:0]                m_axis_tuser
`endif
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]            wr_ptr_q, wr_ptr_d;
  logic [AW:0]            rd_ptr_q, rd_ptr_d;
  logic [LEN_WIDTH-1:0]   beat_cnt_q, beat_cnt_d;
  logic [LEN_WIDTH-1:0]   len_q, len_d;
  logic                   overflow_q, overflow_d;
  logic [CNT_WIDTH-1:0]   drop_cnt_q, drop_cnt_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic                   empty, full, pop, push, wr_en, drop;
  logic [LEN_WIDTH-1:0]   live_len, eff_len;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign pop   = m_axis_tvalid && m_axis_tready;
  assign push  = rdDataEn && (!full || pop);
  // clear wins: the beat arriving with clear is discarded and not counted
  assign wr_en = push && !clear;
  assign drop  = rdDataEn && full && !pop && !clear;

  // A zero length means single-beat packets; the first beat of a packet uses
  // the live length because len_q has not been captured yet.
  assign live_len = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
  assign eff_len  = (beat_cnt_q == '0) ? live_len : len_q;

  assign m_axis_tvalid = !empty;
  assign m_axis_tdata  = mem_q[rd_ptr_q[AW-1:0]];
  assign m_axis_tkeep  = '1;
  assign m_axis_tlast  = m_axis_tvalid && (beat_cnt_q == (eff_len - LEN_WIDTH'(1)));
  assign fill_level    = wr_ptr_q - rd_ptr_q;
  assign overflow      = overflow_q;
  assign drop_cnt      = drop_cnt_q;

  // Next-state for pointers, framing counter and drop accounting
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    beat_cnt_d = beat_cnt_q;
    len_d      = len_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      beat_cnt_d = '0;
      len_d      = live_len;
      overflow_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      // Length is tracked while idle between packets, frozen once a packet starts
      if (beat_cnt_q == '0) len_d = live_len;
      if (pop) beat_cnt_d = m_axis_tlast ? '0 : beat_cnt_q + 1'b1;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 1'b1;
      end
    end
  end

  // Control state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      beat_cnt_q <= '0;
      len_q      <= LEN_WIDTH'(1);
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      beat_cnt_q <= beat_cnt_d;
      len_q      <= len_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Beat storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= rdData;
  end

`ifdef RDATA_SEQ_TAG_EN
  logic [15:0] seq_q, seq_d;
  logic [15:0] tag_q [DEPTH];

  assign m_axis_tuser = tag_q[rd_ptr_q[AW-1:0]];

  // Sequence number advances on every offered beat, accepted or dropped
  always_comb begin
    seq_d = seq_q;
    if (clear)         seq_d = '0;
    else if (rdDataEn) seq_d = seq_q + 16'd1;
  end

  // Sequence counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) seq_q <= '0;
    else     seq_q <= seq_d;
  end

  // Tag storage written alongside the beat
  always_ff @(posedge clk) begin
    if (wr_en) tag_q[wr_ptr_q[AW-1:0]] <= seq_q;
  end
`endif

endmodule
